// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Divider support is controlled by the MULDIV_DIV_EN macro in muldiv_ctrl.sv.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/muldiv_ctrl_abs.sv
// Conditional 32-bit absolute value: negates only when the operand is treated
// as signed and its sign bit is set, and reports that it did so.
module muldiv_abs (
  input  logic [31:0] val,
  input  logic        is_signed,
  output logic [31:0] mag,
  output logic        neg
);

  // Magnitude and sign flag for one operand
  always_comb begin
    neg = is_signed & val[31];
    mag = neg ? -val : val;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Shift-add multiply or restoring divide over ITER iterations, then a sign fix.
// Build option: define MULDIV_DIV_EN to include the divider datapath; without it
// DIV/DIVU complete in one cycle and leave HI/LO untouched.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   load;

  op_e         op_in;
  logic        op_signed;
  logic [31:0] rs_mag, rt_mag;
  logic        rs_neg, rt_neg;

  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      acc_q;
  logic [31:0]      b_q;
  logic             neg_q;
  logic [31:0]      hi_q, lo_q;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [31:0] hi_fix, lo_fix;

`ifdef MULDIV_DIV_EN
  logic        is_div_q;
  logic        rem_neg_q;
  logic [31:0] rs_raw_q;
  logic [32:0] div_tmp, div_trial;
  logic        div_borrow;
  logic [63:0] div_next;
`endif

  assign op_in     = op_e'(op);
  assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);

  muldiv_abs u_abs_rs (
    .val       (rs_val),
    .is_signed (op_signed),
    .mag       (rs_mag),
    .neg       (rs_neg)
  );

  muldiv_abs u_abs_rt (
    .val       (rt_val),
    .is_signed (op_signed),
    .mag       (rt_mag),
    .neg       (rt_neg)
  );

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign stall = mf_req & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // State and done-pulse register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state, operand-load strobe and done request
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          load    = 1'b1;
          state_d = ST_RUN;
`else
          if (op[1]) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
`endif
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration of the multiply (and divide, when built) on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    step_next = mul_next;
`ifdef MULDIV_DIV_EN
    div_tmp    = acc_q[63:31];
    div_trial  = div_tmp - {1'b0, b_q};
    div_borrow = div_trial[32];
    div_next   = {(div_borrow ? div_tmp[31:0] : div_trial[31:0]), acc_q[30:0], ~div_borrow};
    if (is_div_q) step_next = div_next;
`endif
  end

  // Sign correction and HI/LO placement of the finished result
  always_comb begin
    {hi_fix, lo_fix} = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      if (b_q == '0) begin
        lo_fix = '1;
        hi_fix = rs_raw_q;
      end else begin
        lo_fix = neg_q     ? -acc_q[31:0]  : acc_q[31:0];
        hi_fix = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
      end
    end
`endif
  end

  // Operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      rs_raw_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            cnt_q <= '0;
            neg_q <= rs_neg ^ rt_neg;
            b_q   <= rs_mag;
            acc_q <= {32'd0, rt_mag};
`ifdef MULDIV_DIV_EN
            is_div_q  <= op[1];
            rem_neg_q <= rs_neg;
            rs_raw_q  <= rs_val;
            if (op[1]) begin
              b_q   <= rt_mag;
              acc_q <= {32'd0, rs_mag};
            end
`endif
          end
        end
        ST_RUN: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic model of HI/LO.
// Follows the MULDIV_DIV_EN build option of the design.
module tb_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          check_count = 0;
  int          pass_count  = 0;
  logic [31:0] model_hi    = '0;
  logic [31:0] model_lo    = '0;

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mf_req (mf_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic opRuns(input logic [1:0] o);
    return DIV_EN || !o[1];
  endfunction

  // Reference HI/LO from ordinary integer arithmetic
  task automatic modelOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p = sa * sb;
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      default: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            model_lo = 32'hFFFF_FFFF;
            model_hi = a;
          end else if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            model_lo = q[31:0];
            model_hi = r[31:0];
          end else begin
            model_lo = a / b;
            model_hi = a % b;
          end
        end
      end
    endcase
  endtask

  // Issue one op at a falling edge, wait for done, check latency and result
  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    int          cycles;
    int          hold_bad;
    logic        expect_run;
    logic [31:0] old_hi, old_lo;
    expect_run = opRuns(op_i);
    old_hi     = model_hi;
    old_lo     = model_lo;
    op     = op_i;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    op     = 2'($urandom_range(0, 3));
    rs_val = $urandom;
    rt_val = $urandom;
    cycles   = 1;
    hold_bad = 0;
    checkOutput({tag, "/busy_first"}, 64'(busy), 64'(expect_run));
    while (!done && cycles < 60) begin
      if (hi !== old_hi || lo !== old_lo) hold_bad++;
      @(negedge clk);
      cycles++;
    end
    modelOp(op_i, a, b);
    checkOutput({tag, "/latency"}, 64'(cycles), expect_run ? 64'd34 : 64'd1);
    checkOutput({tag, "/hold"}, 64'(hold_bad), 64'd0);
    checkOutput({tag, "/busy_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "/hi"}, 64'(hi), 64'(model_hi));
    checkOutput({tag, "/lo"}, 64'(lo), 64'(model_lo));
  endtask

  initial begin
    int          cycles;
    int          stall_bad;
    int          done_seen;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mf_req = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset/busy", 64'(busy), 64'd0);
    checkOutput("reset/done", 64'(done), 64'd0);
    checkOutput("reset/stall", 64'(stall), 64'd0);
    checkOutput("reset/hi", 64'(hi), 64'd0);
    checkOutput("reset/lo", 64'(lo), 64'd0);
    mf_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg");
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
    applyStimulus(2'b11, 32'd100, 32'd7, "divu_100_7");
    applyStimulus(2'b11, 32'h0000_1234, 32'd0, "divu_by0");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by0_neg");
    applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(done), 64'd0);

    $display("[TB] stall and ignored second start");
    op     = 2'b00;
    rs_val = 32'h0000_1234;
    rt_val = 32'hFFFF_FFFD;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cycles    = 1;
    stall_bad = 0;
    while (!done && cycles < 60) begin
      if (cycles == 5) mf_req = 1'b1;
      if (cycles == 10) begin
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'h0BAD_F00D;
        rt_val = 32'h0000_0777;
      end
      if (cycles == 11) start = 1'b0;
      #1;
      if (cycles >= 5 && stall !== 1'b1) stall_bad++;
      @(negedge clk);
      cycles++;
    end
    #1;
    modelOp(2'b00, 32'h0000_1234, 32'hFFFF_FFFD);
    checkOutput("stall/held", 64'(stall_bad), 64'd0);
    checkOutput("stall/latency", 64'(cycles), 64'd34);
    checkOutput("stall/done_cycle", 64'(stall), 64'd0);
    checkOutput("stall/hi", 64'(hi), 64'(model_hi));
    checkOutput("stall/lo", 64'(lo), 64'(model_lo));
    mf_req = 1'b0;
    @(negedge clk);
    checkOutput("stall/no_second_op", 64'(busy), 64'd0);

    $display("[TB] reset in flight");
    op     = 2'b00;
    rs_val = 32'h0001_0003;
    rt_val = 32'h0000_0005;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset/busy", 64'(busy), 64'd0);
    checkOutput("midreset/done", 64'(done), 64'd0);
    checkOutput("midreset/hi", 64'(hi), 64'd0);
    checkOutput("midreset/lo", 64'(lo), 64'd0);
    model_hi = '0;
    model_lo = '0;
    rst_n    = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("midreset/no_done", 64'(done_seen), 64'd0);
    applyStimulus(2'b00, 32'h0001_0003, 32'h0000_0005, "restart");

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_b = 32'hFFFF_FFFF;
        3: r_a = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus(r_op, r_a, r_b, $sformatf("rand%0d_op%0d", i, r_op));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
